// File: rtl/ao21_bank_pkg.sv
// Shared types and helpers for the AO21 toggle bank: snapshot FSM states,
// popcount, and width/limit helpers for the toggle counter.
package ao21_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACK      = 2'd1,
      ST_WAIT_LOW = 2'd2
   } snap_state_t;

   // Lanes are capped at 64, so a 7-bit count always fits.
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + 7'(v[i]);
      end
      return n;
   endfunction

   function automatic int inc_width(input int w);
      return $clog2(w + 1);
   endfunction

   function automatic logic [31:0] cnt_max(input int cw);
      logic [32:0] one_hot;
      one_hot = 33'd1 << cw;
      return 32'(one_hot - 33'd1);
   endfunction

endpackage

// File: rtl/ao21_toggle_bank_if.sv
// Signal bundle for the AO21 toggle bank: datapath, counter control and the
// snapshot handshake, plus FSM/counter debug taps.
interface ao21_toggle_bank_if
   import ao21_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             EN;
   logic             IN_VLD;
   logic [WIDTH-1:0] IN1;
   logic [WIDTH-1:0] IN2;
   logic [WIDTH-1:0] IN3;
   logic [WIDTH-1:0] Q;
   logic             Q_VLD;
   logic             CLR_CNT;
   // Four-phase snapshot: requester raises SNAP_REQ and holds it until
   // SNAP_ACK is seen high, then drops it; SNAP_CNT is valid while SNAP_ACK
   // is high and a new request may only start after SNAP_ACK has fallen.
   logic             SNAP_REQ;
   logic             SNAP_ACK;
   logic [CNT_W-1:0] SNAP_CNT;
   logic             SAT;
   snap_state_t      snap_st;
   logic [CNT_W-1:0] cnt_dbg;

   modport master (
      output EN, IN_VLD, IN1, IN2, IN3, CLR_CNT, SNAP_REQ,
      input  Q, Q_VLD, SNAP_ACK, SNAP_CNT, SAT, snap_st, cnt_dbg
   );

   modport slave (
      input  EN, IN_VLD, IN1, IN2, IN3, CLR_CNT, SNAP_REQ,
      output Q, Q_VLD, SNAP_ACK, SNAP_CNT, SAT, snap_st, cnt_dbg
   );

endinterface

// File: rtl/ao21_toggle_cnt.sv
// Saturating toggle counter: adds a per-cycle increment, clamps at the
// all-ones value with a sticky SAT flag, and clears on demand.
module ao21_toggle_cnt
   import ao21_bank_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int INC_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_en,
   input  logic [INC_W-1:0] inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);
   // One spare bit over the wider operand so the sum never wraps.
   localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
   localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

   logic [SUM_W-1:0] sum;

   assign sum = SUM_W'(cnt) + SUM_W'(inc);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc_en) begin
         if (sum > MAX_S) begin
            cnt <= CNT_MAX;
            sat <= 1'b1;
         end else begin
            cnt <= sum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ao21_toggle_bank.sv
// Pipelined bank of AO21 lanes with a toggle counter on the final stage and
// a four-phase snapshot port for reading the count.
module ao21_toggle_bank
   import ao21_bank_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                CLK,
   input  logic                RST,
   ao21_toggle_bank_if.slave   bus
);
   localparam int INC_W = inc_width(WIDTH);

   logic [WIDTH-1:0]  ao21_d;
   logic [WIDTH-1:0]  q_pipe [STAGES];
   logic [STAGES-1:0] vld_pipe;
   logic [WIDTH-1:0]  q_next;
   logic [INC_W-1:0]  inc;
   logic [CNT_W-1:0]  cnt;
   logic              sat;

   snap_state_t       state_q, state_d;
   logic              ack_q, ack_d;
   logic              capture;
   logic [CNT_W-1:0]  snap_q;

   assign ao21_d = (bus.IN1 & bus.IN2) | bus.IN3;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < STAGES; k++) begin
            q_pipe[k] <= '0;
         end
         vld_pipe <= '0;
      end else if (bus.EN) begin
         q_pipe[0]   <= ao21_d;
         vld_pipe[0] <= bus.IN_VLD;
         for (int k = 1; k < STAGES; k++) begin
            q_pipe[k]   <= q_pipe[k-1];
            vld_pipe[k] <= vld_pipe[k-1];
         end
      end
   end

   // Value the last stage will take on the next enabled edge.
   generate
      if (STAGES == 1) begin : g_next_direct
         assign q_next = ao21_d;
      end else begin : g_next_pipe
         assign q_next = q_pipe[STAGES-2];
      end
   endgenerate

   assign inc = INC_W'(popcount(64'(q_next ^ q_pipe[STAGES-1])));

   ao21_toggle_cnt #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
   ) u_cnt (
      .clk    (CLK),
      .rst    (RST),
      .inc_en (bus.EN),
      .inc    (inc),
      .clr    (bus.CLR_CNT),
      .cnt    (cnt),
      .sat    (sat)
   );

   // ACK is registered from the state, so it trails the request by two
   // edges on the way up and one edge on the way down.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.SNAP_REQ) begin
               capture = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            ack_d   = 1'b1;
            state_d = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (bus.SNAP_REQ) begin
               ack_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         if (capture) begin
            snap_q <= cnt;
         end
      end
   end

   assign bus.Q        = q_pipe[STAGES-1];
   assign bus.Q_VLD    = vld_pipe[STAGES-1];
   assign bus.SNAP_ACK = ack_q;
   assign bus.SNAP_CNT = snap_q;
   assign bus.SAT      = sat;
   assign bus.snap_st  = state_q;
   assign bus.cnt_dbg  = cnt;

endmodule

// File: tb/tb_ao21_toggle_bank.sv
// Bench for ao21_toggle_bank: a CNT_W=16 and a CNT_W=4 instance share one
// stimulus stream; vectors table plus directed multi-cycle sequences.
module tb_ao21_toggle_bank;
   import ao21_bank_pkg::*;

   logic CLK;
   logic RST;
   int   checks;
   int   errors;

   ao21_toggle_bank_if #(.WIDTH(8), .CNT_W(16)) b16 ();
   ao21_toggle_bank_if #(.WIDTH(8), .CNT_W(4))  b4 ();

   ao21_toggle_bank #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut16 (
      .CLK (CLK),
      .RST (RST),
      .bus (b16)
   );

   ao21_toggle_bank #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut4 (
      .CLK (CLK),
      .RST (RST),
      .bus (b4)
   );

   assign b4.EN       = b16.EN;
   assign b4.IN_VLD   = b16.IN_VLD;
   assign b4.IN1      = b16.IN1;
   assign b4.IN2      = b16.IN2;
   assign b4.IN3      = b16.IN3;
   assign b4.CLR_CNT  = b16.CLR_CNT;
   assign b4.SNAP_REQ = b16.SNAP_REQ;

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic v);
      b16.IN1    = a;
      b16.IN2    = b;
      b16.IN3    = c;
      b16.IN_VLD = v;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] in1;
      logic [7:0] in2;
      logic [7:0] in3;
      logic       vld;
      logic [7:0] exp_q;
      logic       exp_vld;
   } vec_t;

   vec_t       tab[8];
   logic [8:0] exp_q[$];

   initial begin
      logic [8:0] e;
      checks = 0;
      errors = 0;

      tab[0] = '{8'hF0, 8'h3C, 8'h01, 1'b1, 8'h31, 1'b1};
      tab[1] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      tab[2] = '{8'h00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
      tab[3] = '{8'hAA, 8'h55, 8'h00, 1'b1, 8'h00, 1'b1};
      tab[4] = '{8'hAA, 8'hFF, 8'h05, 1'b0, 8'hAF, 1'b0};
      tab[5] = '{8'h0F, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b1};
      tab[6] = '{8'h12, 8'h34, 8'h80, 1'b1, 8'h90, 1'b1};
      tab[7] = '{8'hC3, 8'h81, 8'h24, 1'b0, 8'hA5, 1'b0};

      // reset with random inputs
      RST          = 1'b1;
      b16.EN       = 1'b1;
      b16.CLR_CNT  = 1'b0;
      b16.SNAP_REQ = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         tick();
      end
      check("rst_q", 32'(b16.Q), 32'h00);
      check("rst_q_vld", 32'(b16.Q_VLD), 32'h0);
      check("rst_snap_ack", 32'(b16.SNAP_ACK), 32'h0);
      check("rst_snap_cnt", 32'(b16.SNAP_CNT), 32'h0);
      check("rst_sat", 32'(b16.SAT), 32'h0);
      check("rst_cnt", 32'(b16.cnt_dbg), 32'h0);
      check("rst_state", 32'(b16.snap_st), 32'(ST_IDLE));
      RST = 1'b0;

      // table vectors, two-stage latency through the scoreboard queue
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            drive(tab[i].in1, tab[i].in2, tab[i].in3, tab[i].vld);
            exp_q.push_back({tab[i].exp_vld, tab[i].exp_q});
         end else begin
            drive(8'h00, 8'h00, 8'h00, 1'b0);
         end
         tick();
         if (exp_q.size() == 2 || (i >= 8 && exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check("vec_q", 32'(b16.Q), 32'(e[7:0]));
            check("vec_q_vld", 32'(b16.Q_VLD), 32'(e[8]));
         end
      end

      // toggle count 00 -> FF -> 00 on cleared counters
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      b16.CLR_CNT = 1'b1;
      tick();
      b16.CLR_CNT = 1'b0;
      check("clr_cnt16", 32'(b16.cnt_dbg), 32'd0);
      check("clr_sat4", 32'(b4.SAT), 32'd0);
      drive(8'h00, 8'h00, 8'hFF, 1'b1);
      tick();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      check("tog_q_ff", 32'(b16.Q), 32'hFF);
      check("tog_cnt_8", 32'(b16.cnt_dbg), 32'd8);
      tick();
      check("tog_q_00", 32'(b16.Q), 32'h00);
      check("tog_cnt16", 32'(b16.cnt_dbg), 32'd16);
      check("sat_cnt4", 32'(b4.cnt_dbg), 32'd15);
      check("sat_flag4", 32'(b4.SAT), 32'd1);
      check("nosat16", 32'(b16.SAT), 32'd0);

      // plain snapshot
      b16.SNAP_REQ = 1'b1;
      tick();
      check("snap_ack_e1", 32'(b16.SNAP_ACK), 32'd0);
      tick();
      check("snap_ack_e2", 32'(b16.SNAP_ACK), 32'd1);
      check("snap_cnt16", 32'(b16.SNAP_CNT), 32'd16);
      check("snap_cnt4", 32'(b4.SNAP_CNT), 32'd15);
      b16.SNAP_REQ = 1'b0;
      tick();
      check("snap_ack_fall", 32'(b16.SNAP_ACK), 32'd0);
      check("snap_idle", 32'(b16.snap_st), 32'(ST_IDLE));

      // clear saturated counter
      b16.CLR_CNT = 1'b1;
      tick();
      b16.CLR_CNT = 1'b0;
      check("clr4_cnt", 32'(b4.cnt_dbg), 32'd0);
      check("clr4_sat", 32'(b4.SAT), 32'd0);

      // rebuild count of 16, then snapshot and clear in the same cycle
      drive(8'h00, 8'h00, 8'hFF, 1'b1);
      tick();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      check("re_cnt16", 32'(b16.cnt_dbg), 32'd16);
      b16.SNAP_REQ = 1'b1;
      b16.CLR_CNT  = 1'b1;
      tick();
      b16.CLR_CNT  = 1'b0;
      check("sc_cnt", 32'(b16.cnt_dbg), 32'd0);
      check("sc_snap", 32'(b16.SNAP_CNT), 32'd16);
      check("sc_ack_e1", 32'(b16.SNAP_ACK), 32'd0);
      check("sc_sat4", 32'(b4.SAT), 32'd0);
      drive(8'h00, 8'h00, 8'hFF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("sc_ack_hold", 32'(b16.SNAP_ACK), 32'd1);
         check("sc_no_recap", 32'(b16.SNAP_CNT), 32'd16);
      end
      check("sc_count_on", 32'(b16.cnt_dbg), 32'd8);
      b16.SNAP_REQ = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      check("sc_ack_fall", 32'(b16.SNAP_ACK), 32'd0);

      // clear wins over the same-edge FF -> 00 toggles
      b16.CLR_CNT = 1'b1;
      tick();
      b16.CLR_CNT = 1'b0;
      check("clr_prio_q", 32'(b16.Q), 32'h00);
      check("clr_prio_cnt", 32'(b16.cnt_dbg), 32'd0);
      tick();
      check("clr_prio_hold", 32'(b16.cnt_dbg), 32'd0);

      // stall with changing inputs
      drive(8'h00, 8'h00, 8'h11, 1'b1);
      tick();
      drive(8'h00, 8'h00, 8'h22, 1'b0);
      tick();
      check("pre_stall_q", 32'(b16.Q), 32'h11);
      check("pre_stall_cnt", 32'(b16.cnt_dbg), 32'd2);
      b16.EN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         tick();
         check("stall_q", 32'(b16.Q), 32'h11);
         check("stall_q_vld", 32'(b16.Q_VLD), 32'd1);
         check("stall_cnt", 32'(b16.cnt_dbg), 32'd2);
      end
      b16.EN = 1'b1;
      drive(8'h00, 8'h00, 8'h33, 1'b1);
      tick();
      check("resume_q_b", 32'(b16.Q), 32'h22);
      check("resume_vld_b", 32'(b16.Q_VLD), 32'd0);
      check("resume_cnt_b", 32'(b16.cnt_dbg), 32'd6);
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      check("resume_q_c", 32'(b16.Q), 32'h33);
      check("resume_vld_c", 32'(b16.Q_VLD), 32'd1);
      check("resume_cnt_c", 32'(b16.cnt_dbg), 32'd8);
      check("resume_cnt4", 32'(b4.cnt_dbg), 32'd8);

      // reset mid-handshake
      b16.SNAP_REQ = 1'b1;
      tick();
      tick();
      check("mid_ack", 32'(b16.SNAP_ACK), 32'd1);
      RST = 1'b1;
      tick();
      check("mid_rst_ack", 32'(b16.SNAP_ACK), 32'd0);
      check("mid_rst_snap", 32'(b16.SNAP_CNT), 32'd0);
      RST = 1'b0;
      b16.SNAP_REQ = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
